// File: rtl/pq_req_arbiter.sv
// Round-robin arbiter sharing one priority-queue command port among NUM_REQ requesters.
// One command outstanding at a time, 3-cycle minimum loop; req_ready only in IDLE, cmd held under q_cmd_ready backpressure.
module pq_req_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  KEY_W   = 16,
    localparam int GID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*KEY_W-1:0] req_key,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [KEY_W-1:0]         rsp_key,
    output logic                     rsp_err,
    output logic                     q_cmd_valid,
    output logic                     q_cmd_op,
    output logic [KEY_W-1:0]         q_cmd_key,
    input  logic                     q_cmd_ready,
    input  logic                     q_rsp_valid,
    input  logic [KEY_W-1:0]         q_rsp_key,
    input  logic                     q_rsp_err,
    output logic [GID_W-1:0]         grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [GID_W:0] NUM_REQ_W = (GID_W+1)'(NUM_REQ);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [GID_W-1:0]     r_ptr;
    logic [GID_W-1:0]     r_gid;
    logic [GID_W-1:0]     w_winner;
    logic                 w_found;
    logic [GID_W:0]       w_sum;
    logic [GID_W:0]       w_ptr_inc;
    logic [GID_W-1:0]     w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_ready;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic                 r_cmd_valid;
    logic                 r_cmd_op;
    logic [KEY_W-1:0]     r_cmd_key;
    logic [KEY_W-1:0]     r_rsp_key;
    logic                 r_rsp_err;
    logic [KEY_W-1:0]     w_key_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_key
        assign w_key_arr[g] = req_key[g*KEY_W +: KEY_W];
    end

    // Scan from the far end toward ptr so the candidate closest to ptr is written last and wins.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (GID_W+1)'(k);
            if (w_sum >= NUM_REQ_W) begin
                w_sum = w_sum - NUM_REQ_W;
            end
            if (req_valid[w_sum[GID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[GID_W-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_inc = {1'b0, r_gid} + (GID_W+1)'(1);
        w_ptr_nxt = (w_ptr_inc == NUM_REQ_W) ? '0 : w_ptr_inc[GID_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ready[w_winner] = 1'b1;
                    w_state_nxt       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (q_cmd_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (q_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_gid       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 1'b0;
            r_cmd_key   <= '0;
            r_rsp_valid <= '0;
            r_rsp_key   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= req_op[w_winner];
                        r_cmd_key   <= w_key_arr[w_winner];
                        r_gid       <= w_winner;
                    end
                end
                S_ISSUE: begin
                    if (q_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (q_rsp_valid) begin
                        r_rsp_valid[r_gid] <= 1'b1;
                        r_rsp_key          <= q_rsp_key;
                        r_rsp_err          <= q_rsp_err;
                        r_ptr              <= w_ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_key     = r_rsp_key;
    assign rsp_err     = r_rsp_err;
    assign q_cmd_valid = r_cmd_valid;
    assign q_cmd_op    = r_cmd_op;
    assign q_cmd_key   = r_cmd_key;
    assign grant_id    = r_gid;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/pq_req_arbiter.md
# pq_req_arbiter

Round-robin scheduler that shares one priority-queue command port among NUM_REQ independent requesters. It accepts enqueue/dequeue commands over per-requester valid/ready handshakes and forwards them one at a time to the queue. It routes each queue response back to the requester that issued the command. It sits between the client logic and the QuickQ queue core, and is the only block that drives the queue's command port.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- KEY_W, 16, key/priority width in bits
- GID_W, $clog2(NUM_REQ), grant index width (derived, not overridden)

- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester command valid
- req_op  in  NUM_REQ  per-requester op: 0 = enqueue, 1 = dequeue
- req_key  in  NUM_REQ*KEY_W  per-requester key; requester i uses bits [i*KEY_W +: KEY_W]
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- rsp_valid  out  NUM_REQ  per-requester response strobe, one cycle, one-hot or zero
- rsp_key  out  KEY_W  response key (dequeued key; enqueue echoes queue value)
- rsp_err  out  1  response error (enqueue when full / dequeue when empty)
- q_cmd_valid  out  1  command valid to queue
- q_cmd_op  out  1  command op to queue
- q_cmd_key  out  KEY_W  command key to queue
- q_cmd_ready  in  1  queue accepts command
- q_rsp_valid  in  1  queue response strobe
- q_rsp_key  in  KEY_W  queue response key
- q_rsp_err  in  1  queue response error
- grant_id  out  GID_W  index of the requester currently owning the queue
- busy  out  1  high while a command is outstanding (ISSUE or WAIT)

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner = first i with req_valid[i], searching ptr, ptr+1, … mod NUM_REQ.
  - req_ready[winner] = 1 combinationally; only in IDLE.
  - At the edge: latch op/key into cmd registers, grant_id <= winner, go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - q_cmd_valid = 1 with the latched q_cmd_op/q_cmd_key, held stable.
  - q_cmd_ready = 1 at an edge: go to WAIT. Otherwise hold.
- WAIT:
  - Wait for q_rsp_valid. On that edge:
    - rsp_key <= q_rsp_key
    - rsp_err <= q_rsp_err
    - rsp_valid[grant_id] <= 1 for exactly the next cycle
    - ptr <= (grant_id+1) mod NUM_REQ
    - go to IDLE.
- q_rsp_valid in IDLE or ISSUE is ignored: no response, no state change.
- Exactly one command is outstanding; the queue must not receive a second command before the first response.
- Fairness: a continuously valid requester is granted within NUM_REQ−1 other transactions.
- Requester obligations: hold req_valid/req_op/req_key stable until req_ready. The arbiter does not check this.
- rsp_key/rsp_err hold their last values when rsp_valid is 0.
- Reset (asynchronous, any state):
  - state=IDLE, ptr=0, grant_id=0
  - q_cmd_valid=0, q_cmd_op=0, q_cmd_key=0
  - rsp_valid=0, rsp_key=0, rsp_err=0, busy=0
  - An in-flight command is dropped; no response is ever delivered for it.

## Timing
- Grant: the cycle req_ready is high is the transfer cycle (edge E0).
- q_cmd_valid rises the cycle after E0.
- Minimum loop with q_cmd_ready=1 in that cycle and q_rsp_valid=1 in the next:
  - rsp_valid high 3 cycles after the transfer cycle
  - the FSM is back in IDLE in that same cycle.
- New grant can occur in the same cycle rsp_valid is high, so back-to-back throughput is one command per 3 cycles.
- busy = (state != IDLE), decoded from registered state.
- req_ready is combinational from req_valid and ptr. All other outputs are registered.

## Test plan
- Reset then idle: rst pulse with all req_valid=0 → all outputs 0 and busy=0 for 10 cycles. Unsolicited q_rsp_valid produces no rsp_valid.
- Single enqueue, requester 2: op=0, key=0x00A5, queue with ready=1 and response next cycle (err=0) → req_ready=4'b0100 in cycle 0, q_cmd_key=0x00A5 in cycle 1, rsp_valid=4'b0100 in cycle 3 with rsp_err=0.
- Round-robin rotation, NUM_REQ=4: all req_valid held high → grant order 0,1,2,3,0. Each rsp_valid is one-hot to the granted index.
- Backpressure: q_cmd_ready held low 5 cycles → q_cmd_valid/op/key stable for all 6 cycles and no other req_ready. Queue then delays the response 4 cycles → rsp_valid appears exactly 1 cycle after q_rsp_valid.
- Error pass-through: dequeue from requester 1 answered with q_rsp_err=1, key=0 → rsp_valid=4'b0010, rsp_err=1. ptr advances so requester 2 wins next over requester 1.
- Reset mid-operation: assert rst while in WAIT → q_cmd_valid and busy drop immediately. A later q_rsp_valid yields no rsp_valid, and the next grant starts from requester 0.
